// File: rtl/robot_pkg.sv
// Shared encodings for the robot drive controller: FSM states, move command
// codes, track direction codes and small decode helpers.
package robot_pkg;

  typedef enum logic [2:0] {
    PWR_OFF  = 3'd0,
    WARMUP   = 3'd1,
    IDLE     = 3'd2,
    MOVE     = 3'd3,
    BLOCKED  = 3'd4,
    COOLDOWN = 3'd5
  } state_e;

  localparam logic [2:0] MV_FWD     = 3'b111;
  localparam logic [2:0] MV_LEFT_A  = 3'b101;
  localparam logic [2:0] MV_LEFT_B  = 3'b010;
  localparam logic [2:0] MV_RIGHT_A = 3'b110;
  localparam logic [2:0] MV_RIGHT_B = 3'b001;
  localparam logic [2:0] MV_BACK    = 3'b011;
  localparam logic [2:0] MV_STOP_A  = 3'b000;
  localparam logic [2:0] MV_STOP_B  = 3'b100;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_BACK = 2'b10;

  function automatic logic is_stop(input logic [2:0] code);
    return (code == MV_STOP_A) || (code == MV_STOP_B);
  endfunction

  // Returns {left, right} track directions for a move code.
  function automatic logic [3:0] motor_dirs(input logic [2:0] code);
    case (code)
      MV_FWD:                 return {MOT_FWD,  MOT_FWD};
      MV_LEFT_A, MV_LEFT_B:   return {MOT_BACK, MOT_FWD};
      MV_RIGHT_A, MV_RIGHT_B: return {MOT_FWD,  MOT_BACK};
      MV_BACK:                return {MOT_BACK, MOT_BACK};
      default:                return {MOT_STOP, MOT_STOP};
    endcase
  endfunction

  function automatic logic obstructed(input logic [2:0] code, input logic front,
                                      input logic rear);
    return ((code == MV_FWD) && front) || ((code == MV_BACK) && rear);
  endfunction

endpackage

// File: rtl/robot_drive_ctrl_if.sv
// Remote-command valid/ready handshake carrying a move code and PWM speed.
interface robot_drive_ctrl_if #(parameter int SPEED_W = 4);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [2:0]         move_i;
  logic [SPEED_W-1:0] speed_i;

  modport master (output cmd_valid_i, move_i, speed_i, input cmd_ready_o);
  modport slave  (input cmd_valid_i, move_i, speed_i, output cmd_ready_o);
endinterface

// File: rtl/robot_debounce.sv
// Obstacle sensor debouncer: the flag takes the raw value only after
// DEBOUNCE_CYC consecutive samples that differ from the current flag.
module robot_debounce #(
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic flag_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      flag_o <= 1'b0;
    end else if (raw_i == flag_o) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      flag_o <= raw_i;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/robot_drive_ctrl.sv
// Tracked robot drive controller: engine sequencing, command acceptance,
// timed PWM moves and obstacle abort. Define ROBOT_REAR_TRACKER_EN for rear sensing.
//   state    | meaning
//   PWR_OFF  | engine off, waiting for motor_on_i
//   WARMUP   | engine spinning up for WARMUP_CYC cycles
//   IDLE     | running, accepting commands
//   MOVE     | executing latched command for MOVE_CYC cycles
//   BLOCKED  | move aborted by obstacle, waiting for it to clear
//   COOLDOWN | one-cycle shutdown before PWR_OFF
module robot_drive_ctrl
  import robot_pkg::*;
#(
  parameter int SPEED_W      = 4,
  parameter int WARMUP_CYC   = 8,
  parameter int MOVE_CYC     = 16,
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                motor_on_i,
  output logic                motor_status_o,
  robot_drive_ctrl_if.slave   cmd,
  output logic [1:0]          left_motor_o,
  output logic [1:0]          right_motor_o,
  output logic                left_pwm_o,
  output logic                right_pwm_o,
  input  logic                tracker_fwrd_i,
  input  logic                tracker_back_i,
  output logic [1:0]          tracker_status_o
);
  localparam int TMAX = (WARMUP_CYC > MOVE_CYC) ? WARMUP_CYC : MOVE_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] WARM_LOAD = TW'(WARMUP_CYC - 1);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYC - 1);

  state_e             state_q;
  logic [TW-1:0]      timer_q;
  logic [2:0]         move_q;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W-1:0] pwm_cnt_q;
  logic               ready_q;
  logic               flag_fwrd;
  logic               flag_back;
  logic               pwm_on;

  robot_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_fwrd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .raw_i  (tracker_fwrd_i),
    .flag_o (flag_fwrd)
  );

`ifdef ROBOT_REAR_TRACKER_EN
  robot_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_back (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .raw_i  (tracker_back_i),
    .flag_o (flag_back)
  );
`else
  logic unused_back;
  assign unused_back = tracker_back_i;
  assign flag_back   = 1'b0;
`endif

  // ready_q is only ever set on entry to IDLE, so it mirrors "IDLE with engine on"
  // without a combinational path from motor_on_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PWR_OFF;
      timer_q <= '0;
      move_q  <= MV_STOP_A;
      speed_q <= '0;
      ready_q <= 1'b0;
    end else if (!motor_on_i && (state_q inside {WARMUP, IDLE, MOVE, BLOCKED})) begin
      state_q <= COOLDOWN;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        PWR_OFF: begin
          if (motor_on_i) begin
            state_q <= WARMUP;
            timer_q <= WARM_LOAD;
          end
        end
        WARMUP: begin
          if (timer_q == '0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        IDLE: begin
          if (cmd.cmd_valid_i && ready_q && !is_stop(cmd.move_i)) begin
            move_q  <= cmd.move_i;
            speed_q <= cmd.speed_i;
            timer_q <= MOVE_LOAD;
            ready_q <= 1'b0;
            state_q <= obstructed(cmd.move_i, flag_fwrd, flag_back) ? BLOCKED : MOVE;
          end
        end
        MOVE: begin
          if (obstructed(move_q, flag_fwrd, flag_back)) begin
            state_q <= BLOCKED;
          end else if (timer_q == '0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        BLOCKED: begin
          if (!obstructed(move_q, flag_fwrd, flag_back)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        COOLDOWN: state_q <= PWR_OFF;
        default:  state_q <= PWR_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_q + SPEED_W'(1);
  end

  assign pwm_on          = (state_q == MOVE) && (pwm_cnt_q < speed_q);
  assign left_pwm_o      = pwm_on;
  assign right_pwm_o     = pwm_on;
  assign {left_motor_o, right_motor_o} =
      (state_q == MOVE) ? motor_dirs(move_q) : {MOT_STOP, MOT_STOP};
  assign motor_status_o  = state_q inside {IDLE, MOVE, BLOCKED};
  assign cmd.cmd_ready_o = ready_q;
  assign tracker_status_o = {flag_back, flag_fwrd};

endmodule

// File: tb/tb_robot_drive_ctrl.sv
// Directed-plus-random bench for robot_drive_ctrl at default parameters.
module tb_robot_drive_ctrl;
  localparam int MOVE_CYC = 16;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       motor_on_i;
  logic       motor_status_o;
  logic [1:0] left_motor_o, right_motor_o;
  logic       left_pwm_o, right_pwm_o;
  logic       tracker_fwrd_i, tracker_back_i;
  logic [1:0] tracker_status_o;

  int n_assert = 0;
  int n_fail   = 0;

  robot_drive_ctrl_if #(.SPEED_W(4)) cmd_if ();

  robot_drive_ctrl #(
    .SPEED_W(4), .WARMUP_CYC(8), .MOVE_CYC(16), .DEBOUNCE_CYC(3)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .motor_on_i       (motor_on_i),
    .motor_status_o   (motor_status_o),
    .cmd              (cmd_if.slave),
    .left_motor_o     (left_motor_o),
    .right_motor_o    (right_motor_o),
    .left_pwm_o       (left_pwm_o),
    .right_pwm_o      (right_pwm_o),
    .tracker_fwrd_i   (tracker_fwrd_i),
    .tracker_back_i   (tracker_back_i),
    .tracker_status_o (tracker_status_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {left, right} directions from the command table.
  function automatic logic [3:0] exp_dirs(input logic [2:0] c);
    case (c)
      3'b111:         return 4'b0101;
      3'b101, 3'b010: return 4'b1001;
      3'b110, 3'b001: return 4'b0110;
      3'b011:         return 4'b1010;
      default:        return 4'b0000;
    endcase
  endfunction

  // Engine on was just requested (or reset just released with it held):
  // ready must appear on the 9th edge, not the 8th.
  task automatic warmup(input string tag);
    for (int i = 0; i < 8; i++) step();
    chk({tag, "_ready_early"}, cmd_if.cmd_ready_o, 1'b0);
    chk({tag, "_status_early"}, motor_status_o, 1'b0);
    step();
    chk({tag, "_ready"}, cmd_if.cmd_ready_o, 1'b1);
    chk({tag, "_status"}, motor_status_o, 1'b1);
  endtask

  task automatic send(input logic [2:0] code, input logic [3:0] spd);
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.move_i      = code;
    cmd_if.speed_i     = spd;
    step();
    cmd_if.cmd_valid_i = 1'b0;
  endtask

  // Full unobstructed move; optional front-sensor glitch starting 3 cycles in.
  task automatic do_move(input string tag, input logic [2:0] code, input logic [3:0] spd,
                         input int glitch);
    int dir_ok = 0, pwm_hi = 0, pwm_eq = 0, rdy_lo = 0, flag_hi = 0;
    send(code, spd);
    for (int i = 0; i < MOVE_CYC; i++) begin
      if (glitch > 0 && i == 3) tracker_fwrd_i = 1'b1;
      if (glitch > 0 && i == 3 + glitch) tracker_fwrd_i = 1'b0;
      if ({left_motor_o, right_motor_o} === exp_dirs(code)) dir_ok++;
      if (left_pwm_o === 1'b1) pwm_hi++;
      if (left_pwm_o === right_pwm_o) pwm_eq++;
      if (cmd_if.cmd_ready_o === 1'b0) rdy_lo++;
      if (tracker_status_o[0] === 1'b1) flag_hi++;
      step();
    end
    chk({tag, "_dirs"}, dir_ok, MOVE_CYC);
    chk({tag, "_pwm_duty"}, pwm_hi, {28'd0, spd});
    chk({tag, "_pwm_same"}, pwm_eq, MOVE_CYC);
    chk({tag, "_busy"}, rdy_lo, MOVE_CYC);
    chk({tag, "_end_motors"}, {left_motor_o, right_motor_o}, 4'b0000);
    chk({tag, "_end_ready"}, cmd_if.cmd_ready_o, 1'b1);
    if (glitch > 0) chk({tag, "_glitch_flag"}, flag_hi, 0);
  endtask

  task automatic check_off(input string tag);
    chk({tag, "_status"}, motor_status_o, 1'b0);
    chk({tag, "_ready"}, cmd_if.cmd_ready_o, 1'b0);
    chk({tag, "_motors"}, {left_motor_o, right_motor_o}, 4'b0000);
    chk({tag, "_pwm"}, {left_pwm_o, right_pwm_o}, 2'b00);
  endtask

  initial begin
    logic [2:0] codes [6];
    logic [2:0] stops [2];
    codes = '{3'b111, 3'b101, 3'b010, 3'b110, 3'b001, 3'b011};
    stops = '{3'b000, 3'b100};

    rst_i = 1'b1;
    motor_on_i = 1'b0;
    tracker_fwrd_i = 1'b0;
    tracker_back_i = 1'b0;
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.move_i = 3'b000;
    cmd_if.speed_i = 4'd0;
    step();
    step();
    check_off("reset");
    chk("reset_trk", tracker_status_o, 2'b00);

    rst_i = 1'b0;
    motor_on_i = 1'b1;
    warmup("warm");

    do_move("fwd4", 3'b111, 4'd4, 0);

    for (int k = 0; k < 6; k++)
      do_move("rand", codes[$urandom_range(0, 5)], 4'($urandom_range(0, 15)), 0);

    for (int k = 0; k < 2; k++) begin
      send(stops[k], 4'($urandom_range(1, 15)));
      chk("stop_ready", cmd_if.cmd_ready_o, 1'b1);
      chk("stop_motors", {left_motor_o, right_motor_o}, 4'b0000);
      chk("stop_status", motor_status_o, 1'b1);
    end

    do_move("glitch", 3'b111, 4'($urandom_range(1, 15)), 2);

    // Obstacle appearing mid forward move.
    send(3'b111, 4'd15);
    step(); step(); step();
    tracker_fwrd_i = 1'b1;
    step(); step();
    chk("deb_2cyc", tracker_status_o, 2'b00);
    step();
    chk("deb_3cyc", tracker_status_o, 2'b01);
    chk("blk_prev_motors", {left_motor_o, right_motor_o}, 4'b0101);
    step();
    chk("blk_motors", {left_motor_o, right_motor_o}, 4'b0000);
    chk("blk_pwm", {left_pwm_o, right_pwm_o}, 2'b00);
    chk("blk_status", motor_status_o, 1'b1);
    chk("blk_ready", cmd_if.cmd_ready_o, 1'b0);
    tracker_fwrd_i = 1'b0;
    step(); step(); step();
    chk("blk_clear_flag", tracker_status_o, 2'b00);
    chk("blk_hold", cmd_if.cmd_ready_o, 1'b0);
    step();
    chk("blk_exit", cmd_if.cmd_ready_o, 1'b1);

    // Front obstacle present at transfer: turns proceed, forward blocks at once.
    tracker_fwrd_i = 1'b1;
    step(); step(); step();
    chk("front_flag", tracker_status_o, 2'b01);
    do_move("turn_obst", 3'b101, 4'($urandom_range(0, 15)), 0);
    send(3'b111, 4'd7);
    chk("xfer_blk_motors", {left_motor_o, right_motor_o}, 4'b0000);
    chk("xfer_blk_ready", cmd_if.cmd_ready_o, 1'b0);
    tracker_fwrd_i = 1'b0;
    step(); step(); step();
    chk("xfer_blk_hold", cmd_if.cmd_ready_o, 1'b0);
    step();
    chk("xfer_blk_exit", cmd_if.cmd_ready_o, 1'b1);

    // Rear obstacle and a backward move.
    tracker_back_i = 1'b1;
    step(); step(); step();
`ifdef ROBOT_REAR_TRACKER_EN
    chk("rear_flag", tracker_status_o, 2'b10);
    send(3'b011, 4'd9);
    chk("rear_blk_motors", {left_motor_o, right_motor_o}, 4'b0000);
    chk("rear_blk_ready", cmd_if.cmd_ready_o, 1'b0);
    tracker_back_i = 1'b0;
    step(); step(); step();
    chk("rear_blk_hold", cmd_if.cmd_ready_o, 1'b0);
    step();
    chk("rear_blk_exit", cmd_if.cmd_ready_o, 1'b1);
`else
    chk("rear_flag", tracker_status_o, 2'b00);
    do_move("back_noblk", 3'b011, 4'($urandom_range(0, 15)), 0);
    chk("rear_flag_after", tracker_status_o, 2'b00);
    tracker_back_i = 1'b0;
`endif

    // Engine off mid-move.
    send(3'b110, 4'd12);
    step(); step(); step(); step();
    motor_on_i = 1'b0;
    step();
    check_off("cool");
    step();
    chk("off_status", motor_status_o, 1'b0);
    motor_on_i = 1'b1;
    warmup("rewarm");

    // Synchronous reset mid-move, with the rear sensor asserted.
    tracker_back_i = 1'b1;
    step(); step(); step();
    send(3'b010, 4'd15);
    step(); step(); step();
    chk("pre_rst_motors", {left_motor_o, right_motor_o}, 4'b1001);
    rst_i = 1'b1;
    tracker_back_i = 1'b0;
    step();
    check_off("mid_rst");
    chk("mid_rst_trk", tracker_status_o, 2'b00);
    step();
    rst_i = 1'b0;
    warmup("post_rst");

    do_move("final", codes[$urandom_range(0, 5)], 4'($urandom_range(0, 15)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/robot_drive_ctrl.md
ROBOT_DRIVE_CTRL -- requirements
Module: robot_drive_ctrl

Interface
REQ-001 SHALL have parameter SPEED_W, default 4, PWM speed word width (>=2).
REQ-002 SHALL have parameter WARMUP_CYC, default 8, engine warm-up duration in cycles (>=1).
REQ-003 SHALL have parameter MOVE_CYC, default 16, duration of one accepted move command in cycles (>=1).
REQ-004 SHALL have parameter DEBOUNCE_CYC, default 3, tracker debounce length in cycles (>=1).
REQ-005 SHALL have: clk_i  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have: rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have: motor_on_i  in  1  engine enable request.
REQ-008 SHALL have: motor_status_o  out  1  engine running (IDLE/MOVE/BLOCKED).
REQ-009 SHALL have: cmd_valid_i  in  1 / cmd_ready_o  out  1  remote-command handshake.
REQ-010 SHALL have: move_i  in  3  command code: 111 fwd, 101/010 left, 110/001 right, 011 back, 000/100 stop.
REQ-011 SHALL have: speed_i  in  SPEED_W  PWM duty, sampled with command.
REQ-012 SHALL have: left_motor_o, right_motor_o  out  2 each  00 stop, 01 forward, 10 backward.
REQ-013 SHALL have: left_pwm_o, right_pwm_o  out  1 each  track PWM enable.
REQ-014 SHALL have: tracker_fwrd_i, tracker_back_i  in  1 each  raw front/rear obstacle sensors.
REQ-015 SHALL have: tracker_status_o  out  2  debounced {rear, front} obstacle flags.

Function
REQ-016 FSM states SHALL be PWR_OFF, WARMUP, IDLE, MOVE, BLOCKED, COOLDOWN; outputs SHALL depend only on registered state/counters (no input-to-output path).
REQ-017 PWR_OFF -> WARMUP when motor_on_i=1; WARMUP lasts exactly WARMUP_CYC cycles then -> IDLE.
REQ-018 In WARMUP/IDLE/MOVE/BLOCKED, motor_on_i=0 SHALL -> COOLDOWN next cycle (overrides all else); COOLDOWN lasts 1 cycle then -> PWR_OFF.
REQ-019 cmd_ready_o SHALL be 1 only in IDLE with motor_on_i=1; transfer occurs when cmd_valid_i & cmd_ready_o.
REQ-020 On transfer of a stop code, state SHALL remain IDLE; otherwise move_i and speed_i SHALL be latched and state -> MOVE next cycle.
REQ-021 MOVE SHALL last exactly MOVE_CYC cycles then -> IDLE; motor direction outputs per latched code (fwd 01/01, left 10/01, right 01/10, back 10/10), 00/00 in every other state.
REQ-022 Free-running SPEED_W-bit PWM counter; in MOVE, pwm_o = (counter < latched speed), both tracks identical; pwm_o=0 outside MOVE; speed 0 -> always 0.
REQ-023 Forward move: debounced front flag =1 in MOVE or at transfer SHALL -> BLOCKED next cycle (transfer goes directly to BLOCKED).
REQ-024 Backward move: same rule using debounced rear flag. Turns SHALL ignore trackers.
REQ-025 BLOCKED SHALL hold motors 00, pwm 0, until the triggering debounced flag clears, then -> IDLE.
REQ-026 Debounced flag SHALL change only after DEBOUNCE_CYC consecutive cycles of the opposite raw value; tracker_status_o reflects flags in all states.

Reset
REQ-027 rst_i=1 SHALL force PWR_OFF, all counters 0, flags 0, latched command stop, speed 0, on the next rising edge, overriding any state including mid-MOVE.
REQ-028 During/after reset: motor_status_o=0, cmd_ready_o=0, motors 00, pwm 0, tracker_status_o=00.

Configuration
REQ-029 Macro ROBOT_REAR_TRACKER_EN defined: rear debounce and REQ-024 back-abort active.
REQ-030 Not defined: tracker_back_i ignored, tracker_status_o[1] tied 0, backward moves never blocked; port list unchanged.

Structure
REQ-031 Package robot_pkg SHALL hold state encodings, move_i codes and motor direction codes (00/01/10).
REQ-032 Sub-module robot_debounce (parameter DEBOUNCE_CYC) SHALL be instantiated once per tracker.

Verification
REQ-033 motor_on_i=1 from reset, WARMUP_CYC=8 -> cmd_ready_o=1 exactly 9 cycles after motor_on_i sampled, motor_status_o=1 from IDLE.
REQ-034 IDLE, transfer 111 speed=4 (SPEED_W=4) -> motors 01/01 for 16 cycles, pwm high 4 of every 16 cycles, then IDLE, cmd_ready_o=1.
REQ-035 Fwd MOVE, tracker_fwrd_i=1 held 3 cycles -> tracker_status_o=01, BLOCKED next cycle, motors 00; release 3 cycles -> IDLE.
REQ-036 Back move with rear obstacle -> BLOCKED with macro; full 16-cycle move, tracker_status_o[1]=0 without.
REQ-037 motor_on_i=0 mid-MOVE -> COOLDOWN, motors 00 next cycle, PWR_OFF after 1 cycle; rst_i=1 mid-MOVE -> all outputs reset next edge.
REQ-038 tracker_fwrd_i glitch 2 cycles (DEBOUNCE_CYC=3) -> flag stays 0, forward move completes unblocked.
